// File: rtl/beacon_scheduler.sv
// Beacon scheduler: tracks the target TBTT against the running TSF and raises
// start_beaconing one lead time early, with catch-up on late TBTTs and a send timeout.
module beacon_scheduler #(
  parameter int unsigned TIMER_WIDTH = 64,
  parameter int unsigned LEAD_MAX_US = 2000,
  parameter int unsigned TIMEOUT_US  = 10000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [15:0]            bi_tu,
  input  logic                   tbtt_load,
  input  logic [TIMER_WIDTH-1:0] tbtt_init,
  input  logic [15:0]            guard_us,
  input  logic [TIMER_WIDTH-1:0] tsf_runtime_val,
  input  logic [TIMER_WIDTH-1:0] prosessing_delay,
  input  logic                   sent_beacon,
  output logic                   start_beaconing,
  output logic [TIMER_WIDTH-1:0] next_tbtt,
  output logic [15:0]            beacon_count,
  output logic [15:0]            missed_count,
  output logic                   abort_pulse
);

  localparam int unsigned EW = TIMER_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CATCHUP = 2'd2,
    ST_BEACON  = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   start_q;
  logic                   abort_q;
  logic                   loaded_q;
  logic [TIMER_WIDTH-1:0] next_tbtt_q;
  logic [15:0]            beacon_count_q;
  logic [15:0]            missed_count_q;
  logic [EW-1:0]          lead_q;

  logic [EW-1:0]          lead_max_s;
  logic [EW-1:0]          delay_clamped_s;
  logic [EW-1:0]          lead_d;
  logic [EW-1:0]          bi_us_s;
  logic [EW-1:0]          tsf_plus_lead_s;
  logic [EW-1:0]          tbtt_next_d;
  logic [EW-1:0]          deadline_s;
  logic [15:0]            missed_inc_s;
  logic                   run_s;
  logic                   late_s;
  logic                   trigger_s;
  logic                   timeout_s;
  logic                   catchup_done_s;

  // Lead time, interval and comparison terms; sums are one bit wider so nothing overflows
  always_comb begin
    lead_max_s      = EW'(LEAD_MAX_US);
    delay_clamped_s = ({1'b0, prosessing_delay} > lead_max_s) ? lead_max_s : {1'b0, prosessing_delay};
    lead_d          = delay_clamped_s + EW'(guard_us);
    bi_us_s         = EW'({bi_tu, 10'd0});
    tsf_plus_lead_s = {1'b0, tsf_runtime_val} + lead_q;
    tbtt_next_d     = {1'b0, next_tbtt_q} + bi_us_s;
    deadline_s      = {1'b0, next_tbtt_q} + EW'(TIMEOUT_US);
    missed_inc_s    = (missed_count_q == 16'hFFFF) ? missed_count_q : (missed_count_q + 16'd1);
    run_s           = enable && (bi_tu != 16'd0);
    late_s          = (tsf_runtime_val >= next_tbtt_q);
    trigger_s       = (tsf_plus_lead_s >= {1'b0, next_tbtt_q});
    timeout_s       = ({1'b0, tsf_runtime_val} >= deadline_s);
    catchup_done_s  = (tbtt_next_d > tsf_plus_lead_s);
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      start_q        <= 1'b0;
      abort_q        <= 1'b0;
      loaded_q       <= 1'b0;
      next_tbtt_q    <= {TIMER_WIDTH{1'b0}};
      beacon_count_q <= 16'd0;
      missed_count_q <= 16'd0;
      lead_q         <= {EW{1'b0}};
    end else begin
      abort_q <= 1'b0;
      // A load is captured even while disabled so re-enabling starts from it
      if (tbtt_load) begin
        next_tbtt_q <= tbtt_init;
        loaded_q    <= 1'b1;
      end
      if (!run_s) begin
        state_q <= ST_IDLE;
        start_q <= 1'b0;
      end else if (tbtt_load) begin
        state_q <= ST_WAIT;
        start_q <= 1'b0;
        lead_q  <= lead_d;
      end else begin
        case (state_q)
          ST_IDLE: begin
            start_q <= 1'b0;
            if (loaded_q) begin
              state_q <= ST_WAIT;
              lead_q  <= lead_d;
            end
          end
          ST_WAIT: begin
            if (late_s) begin
              state_q <= ST_CATCHUP;
            end else if (trigger_s) begin
              state_q <= ST_BEACON;
              start_q <= 1'b1;
            end
          end
          ST_CATCHUP: begin
            next_tbtt_q    <= tbtt_next_d[TIMER_WIDTH-1:0];
            missed_count_q <= missed_inc_s;
            if (catchup_done_s) begin
              state_q <= ST_WAIT;
              lead_q  <= lead_d;
            end
          end
          ST_BEACON: begin
            // sent_beacon wins over a coinciding timeout
            if (sent_beacon) begin
              state_q        <= ST_WAIT;
              start_q        <= 1'b0;
              next_tbtt_q    <= tbtt_next_d[TIMER_WIDTH-1:0];
              beacon_count_q <= beacon_count_q + 16'd1;
              lead_q         <= lead_d;
            end else if (timeout_s) begin
              state_q        <= ST_WAIT;
              start_q        <= 1'b0;
              abort_q        <= 1'b1;
              next_tbtt_q    <= tbtt_next_d[TIMER_WIDTH-1:0];
              missed_count_q <= missed_inc_s;
              lead_q         <= lead_d;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign start_beaconing = start_q;
  assign abort_pulse     = abort_q;
  assign next_tbtt       = next_tbtt_q;
  assign beacon_count    = beacon_count_q;
  assign missed_count    = missed_count_q;

endmodule

// File: tb/tb_beacon_scheduler.sv
// Directed bench for beacon_scheduler: TSF is stepped by the bench, one us per clock,
// with jumps to bring each scenario close to its event.
module tb_beacon_scheduler;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] bi_tu;
  logic        tbtt_load;
  logic [63:0] tbtt_init;
  logic [15:0] guard_us;
  logic [63:0] tsf_runtime_val;
  logic [63:0] prosessing_delay;
  logic        sent_beacon;
  logic        start_beaconing;
  logic [63:0] next_tbtt;
  logic [15:0] beacon_count;
  logic [15:0] missed_count;
  logic        abort_pulse;

  int checks;
  int failures;

  beacon_scheduler #(
    .TIMER_WIDTH (64),
    .LEAD_MAX_US (2000),
    .TIMEOUT_US  (10000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .bi_tu            (bi_tu),
    .tbtt_load        (tbtt_load),
    .tbtt_init        (tbtt_init),
    .guard_us         (guard_us),
    .tsf_runtime_val  (tsf_runtime_val),
    .prosessing_delay (prosessing_delay),
    .sent_beacon      (sent_beacon),
    .start_beaconing  (start_beaconing),
    .next_tbtt        (next_tbtt),
    .beacon_count     (beacon_count),
    .missed_count     (missed_count),
    .abort_pulse      (abort_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: the edge samples the current TSF, then TSF advances by 1 us
  task automatic tick();
    @(posedge clk);
    #2;
    tsf_runtime_val = tsf_runtime_val + 64'd1;
  endtask

  task automatic wait_start(input string tag, input int budget, input logic [63:0] exp_tsf);
    logic [63:0] t_prev;
    bit          seen;
    seen   = 1'b0;
    t_prev = 64'd0;
    for (int i = 0; i < budget && !seen; i++) begin
      t_prev = tsf_runtime_val;
      tick();
      if (start_beaconing) seen = 1'b1;
    end
    check_val({tag, "_rise"}, 64'(seen), 64'd1);
    check_val({tag, "_tsf"}, t_prev, exp_tsf);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t_prev;
    bit          seen;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    enable = 1'b0;
    bi_tu = 16'd0;
    tbtt_load = 1'b0;
    tbtt_init = 64'd0;
    guard_us = 16'd0;
    tsf_runtime_val = 64'd0;
    prosessing_delay = 64'd0;
    sent_beacon = 1'b0;
    #3;
    check_val("rst_start", 64'(start_beaconing), 64'd0);
    check_val("rst_tbtt", next_tbtt, 64'd0);
    check_val("rst_bcnt", 64'(beacon_count), 64'd0);
    check_val("rst_miss", 64'(missed_count), 64'd0);
    check_val("rst_abort", 64'(abort_pulse), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    bi_tu = 16'd100;
    guard_us = 16'd50;
    prosessing_delay = 64'd150;
    tsf_runtime_val = 64'd990000;
    tick();
    tick();
    check_val("idle_no_load", 64'(start_beaconing), 64'd0);

    // Nominal beacon
    tbtt_init = 64'd1000000;
    tbtt_load = 1'b1;
    tick();
    tbtt_load = 1'b0;
    check_val("nom_load_tbtt", next_tbtt, 64'd1000000);
    tsf_runtime_val = 64'd999700;
    wait_start("nom", 200, 64'd999800);
    while (tsf_runtime_val != 64'd1000100) tick();
    check_val("nom_hold", 64'(start_beaconing), 64'd1);
    sent_beacon = 1'b1;
    tick();
    sent_beacon = 1'b0;
    check_val("nom_start_fall", 64'(start_beaconing), 64'd0);
    check_val("nom_tbtt", next_tbtt, 64'd1102400);
    check_val("nom_bcnt", 64'(beacon_count), 64'd1);

    // Timeout without sent_beacon
    tsf_runtime_val = 64'd1102190;
    wait_start("to", 50, 64'd1102200);
    tsf_runtime_val = 64'd1112395;
    seen = 1'b0;
    t_prev = 64'd0;
    for (int i = 0; i < 20 && !seen; i++) begin
      t_prev = tsf_runtime_val;
      tick();
      if (abort_pulse) seen = 1'b1;
    end
    check_val("to_abort", 64'(seen), 64'd1);
    check_val("to_tsf", t_prev, 64'd1112400);
    check_val("to_start", 64'(start_beaconing), 64'd0);
    check_val("to_miss", 64'(missed_count), 64'd1);
    check_val("to_tbtt", next_tbtt, 64'd1204800);
    tick();
    check_val("to_abort_1cyc", 64'(abort_pulse), 64'd0);

    // sent_beacon coinciding with the timeout counts as sent
    tsf_runtime_val = 64'd1204590;
    wait_start("tos", 50, 64'd1204600);
    tsf_runtime_val = 64'd1214790;
    while (tsf_runtime_val != 64'd1214800) tick();
    sent_beacon = 1'b1;
    tick();
    sent_beacon = 1'b0;
    check_val("tos_abort", 64'(abort_pulse), 64'd0);
    check_val("tos_bcnt", 64'(beacon_count), 64'd2);
    check_val("tos_miss", 64'(missed_count), 64'd1);
    check_val("tos_tbtt", next_tbtt, 64'd1307200);

    // Lead clamp
    prosessing_delay = 64'd5000;
    guard_us = 16'd0;
    tsf_runtime_val = 64'd1990000;
    tbtt_init = 64'd2000000;
    tbtt_load = 1'b1;
    tick();
    tbtt_load = 1'b0;
    tsf_runtime_val = 64'd1997990;
    wait_start("clamp", 50, 64'd1998000);

    // Reload during BEACON
    tbtt_init = 64'd3000000;
    tbtt_load = 1'b1;
    tick();
    tbtt_load = 1'b0;
    check_val("rld_start", 64'(start_beaconing), 64'd0);
    check_val("rld_tbtt", next_tbtt, 64'd3000000);
    check_val("rld_bcnt", 64'(beacon_count), 64'd2);

    // Enable drop in BEACON, sent_beacon ignored while idle
    tsf_runtime_val = 64'd2997990;
    wait_start("en", 50, 64'd2998000);
    enable = 1'b0;
    tick();
    check_val("en_start", 64'(start_beaconing), 64'd0);
    sent_beacon = 1'b1;
    tick();
    sent_beacon = 1'b0;
    check_val("en_sent_ign", 64'(beacon_count), 64'd2);
    check_val("en_tbtt_keep", next_tbtt, 64'd3000000);
    enable = 1'b1;
    tick();
    tick();
    check_val("en_resume", 64'(start_beaconing), 64'd1);

    // Asynchronous reset mid-BEACON
    #1;
    rst = 1'b1;
    #1;
    check_val("arst_start", 64'(start_beaconing), 64'd0);
    check_val("arst_tbtt", next_tbtt, 64'd0);
    check_val("arst_bcnt", 64'(beacon_count), 64'd0);
    check_val("arst_miss", 64'(missed_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check_val("arst_idle", 64'(start_beaconing), 64'd0);

    // Late load: three catch-up steps
    prosessing_delay = 64'd150;
    guard_us = 16'd50;
    tsf_runtime_val = 64'd800000;
    tbtt_init = 64'd500000;
    tbtt_load = 1'b1;
    tick();
    tbtt_load = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_val("late_tbtt", next_tbtt, 64'd807200);
    check_val("late_miss", 64'(missed_count), 64'd3);
    tick();
    check_val("late_miss_hold", 64'(missed_count), 64'd3);
    check_val("late_no_start", 64'(start_beaconing), 64'd0);
    tsf_runtime_val = 64'd806990;
    wait_start("late", 50, 64'd807000);

    // bi_tu=0 drops the request
    bi_tu = 16'd0;
    tick();
    check_val("bi0_start", 64'(start_beaconing), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beacon_scheduler.md
BEACON_SCHEDULER -- requirements
Module: beacon_scheduler

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 64, giving the width of the TSF and TBTT values in microseconds.
REQ-002 SHALL have parameter LEAD_MAX_US, default 2000, giving the upper clamp on the measured-delay part of the lead time.
REQ-003 SHALL have parameter TIMEOUT_US, default 10000, giving the maximum time past TBTT to wait for sent_beacon.
REQ-004 SHALL have ports:
- clk  in  1  -- single clock.
- rst  in  1  -- reset, asynchronous and active-high.
- enable  in  1  -- level; scheduler runs while high.
- bi_tu  in  16  -- beacon interval in TU (1 TU = 1024 us).
- tbtt_load  in  1  -- pulse; loads tbtt_init.
- tbtt_init  in  TIMER_WIDTH  -- first TBTT in us.
- guard_us  in  16  -- fixed extra lead in us.
- tsf_runtime_val  in  TIMER_WIDTH  -- current TSF in us.
- prosessing_delay  in  TIMER_WIDTH  -- measured start-to-sent delay from the downstream TSF tracker.
- sent_beacon  in  1  -- pulse; beacon air transmission done.
- start_beaconing  out  1  -- level request to the TX path.
- next_tbtt  out  TIMER_WIDTH  -- current target TBTT.
- beacon_count  out  16  -- beacons sent, wraps.
- missed_count  out  16  -- TBTTs skipped or timed out, saturates at 0xFFFF.
- abort_pulse  out  1  -- one-cycle pulse on timeout.

Function
REQ-005 SHALL implement an FSM with states IDLE, WAIT, CATCHUP and BEACON; all outputs registered.
REQ-006 SHALL compute bi_us as bi_tu shifted left by 10, zero-extended to TIMER_WIDTH; all comparisons SHALL be unsigned, with no TSF wrap handling.
REQ-007 SHALL compute lead as min(prosessing_delay, LEAD_MAX_US) + guard_us, and latch it into a register on every entry to WAIT.
REQ-008 IDLE: start_beaconing=0. Go to WAIT when enable=1, bi_tu!=0 and a TBTT has been loaded since reset; otherwise remain in IDLE.
REQ-009 WAIT, case tsf_runtime_val >= next_tbtt (late): go to CATCHUP.
REQ-010 WAIT, case tsf_runtime_val + lead >= next_tbtt: go to BEACON and set start_beaconing=1 on the next edge.
REQ-011 WAIT, all other cases: hold.
REQ-012 CATCHUP: each cycle, next_tbtt += bi_us and missed_count += 1 (saturating); return to WAIT once next_tbtt > tsf_runtime_val + lead (evaluated on the updated value).
REQ-013 BEACON: start_beaconing held at 1. On sent_beacon: start_beaconing=0, next_tbtt += bi_us, beacon_count += 1, go to WAIT.
REQ-014 BEACON, timeout: if tsf_runtime_val >= next_tbtt + TIMEOUT_US with no sent_beacon, then start_beaconing=0, abort_pulse=1 for one cycle, next_tbtt += bi_us, missed_count += 1, go to WAIT.
REQ-015 Trigger latency: start_beaconing SHALL rise exactly one clk after the cycle in which the WAIT trigger condition holds.
REQ-016 sent_beacon in the same cycle as the timeout condition SHALL count as sent; no abort is raised.
REQ-017 sent_beacon outside BEACON SHALL be ignored.
REQ-018 tbtt_load in any state: next_tbtt=tbtt_init, start_beaconing=0, counters unchanged, next state WAIT (or IDLE if enable=0 or bi_tu=0).
REQ-019 enable=0 or bi_tu=0 in any state: next edge start_beaconing=0, go to IDLE; next_tbtt is retained.
REQ-020 Priority: rst > (enable=0 or bi_tu=0) > tbtt_load > sent_beacon > timeout > trigger.
REQ-021 A change of bi_tu while enabled SHALL take effect on the next next_tbtt increment.

Reset
REQ-022 On rst=1, asynchronously: state=IDLE, start_beaconing=0, abort_pulse=0, next_tbtt=0, beacon_count=0, missed_count=0, lead=0, tbtt-loaded flag=0.
REQ-023 Reset asserted mid-BEACON SHALL drop start_beaconing immediately without a clk edge.
REQ-024 After rst deasserts, the block SHALL remain in IDLE until tbtt_load is seen.

Verification
REQ-025 Nominal: bi_tu=100, tbtt_init=1,000,000, guard=50, delay=150, TSF advancing 1 us per cycle from 990,000 -> start_beaconing rises at TSF 999,800 +1 clk; sent_beacon at 1,000,100 -> next_tbtt=1,102,400, beacon_count=1.
REQ-026 Late load: tbtt_init=500,000 loaded at TSF=800,000 with bi_tu=100 -> CATCHUP runs 3 cycles, next_tbtt=807,200, missed_count=3, no start_beaconing until TSF reaches 807,200 - lead.
REQ-027 Timeout: no sent_beacon -> abort_pulse one cycle at TSF = TBTT + 10,000, missed_count += 1, next_tbtt += 102,400; with sent_beacon in the same cycle -> beacon_count += 1 and no abort.
REQ-028 Clamp: prosessing_delay=5000, guard=0 -> lead=2000; trigger at TBTT - 2000.
REQ-029 Control: drop enable while in BEACON -> start_beaconing=0 next edge and IDLE; assert rst mid-BEACON -> all outputs zero asynchronously.
REQ-030 Reload: tbtt_load during BEACON -> start_beaconing falls, next_tbtt=tbtt_init, beacon_count unchanged.
